// File: rtl/func_grad_seq.sv
// Central-difference sequencer: drives one evaluator through f(x+H) then f(x-H)
// over the start_func/func_done four-phase handshake and forms their difference.
module func_grad_seq #(
  parameter logic signed [31:0] H       = 32'sh00000010,
  parameter int                 TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [31:0]  x_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] y_plus,
  output logic [127:0] y_minus,
  output logic [127:0] diff,
  output logic         sat,
  output logic         ovf,
  output logic         timeout_err,
  output logic         start_func,
  output logic [31:0]  x_func,
  input  logic [127:0] y_func,
  input  logic         func_done
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ_P, REL_P, REQ_M, REL_M, DIFF, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic [31:0]     x_minus;
  logic [32:0]     sum_p, sum_m;
  logic [31:0]     sat_p, sat_m;
  logic            clamp_p, clamp_m;
  logic [127:0]    diff_calc;
  logic            ovf_calc;
  logic            timed_out;

  // 33-bit sums expose signed overflow as a mismatch between the top two bits
  always_comb begin
    sum_p     = {x_in[31], x_in} + {H[31], H};
    sum_m     = {x_in[31], x_in} - {H[31], H};
    clamp_p   = sum_p[32] ^ sum_p[31];
    clamp_m   = sum_m[32] ^ sum_m[31];
    sat_p     = clamp_p ? (sum_p[32] ? 32'h80000000 : 32'h7FFFFFFF) : sum_p[31:0];
    sat_m     = clamp_m ? (sum_m[32] ? 32'h80000000 : 32'h7FFFFFFF) : sum_m[31:0];
    diff_calc = y_plus - y_minus;
    ovf_calc  = (y_plus[127] != y_minus[127]) && (diff_calc[127] != y_plus[127]);
    timed_out = (wait_cnt == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      x_minus     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      y_plus      <= '0;
      y_minus     <= '0;
      diff        <= '0;
      sat         <= 1'b0;
      ovf         <= 1'b0;
      timeout_err <= 1'b0;
      start_func  <= 1'b0;
      x_func      <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A stale func_done from an aborted handshake must drop before a new request
          if (start && !func_done) begin
            x_minus     <= sat_m;
            x_func      <= sat_p;
            sat         <= clamp_p | clamp_m;
            ovf         <= 1'b0;
            timeout_err <= 1'b0;
            y_plus      <= '0;
            y_minus     <= '0;
            diff        <= '0;
            start_func  <= 1'b1;
            busy        <= 1'b1;
            wait_cnt    <= '0;
            state       <= REQ_P;
          end
        end
        REQ_P, REL_P, REQ_M, REL_M: begin
          if ((state == REQ_P || state == REQ_M) ? func_done : !func_done) begin
            wait_cnt <= '0;
            case (state)
              REQ_P: begin
                y_plus     <= y_func;
                start_func <= 1'b0;
                state      <= REL_P;
              end
              REL_P: begin
                x_func     <= x_minus;
                start_func <= 1'b1;
                state      <= REQ_M;
              end
              REQ_M: begin
                y_minus    <= y_func;
                start_func <= 1'b0;
                state      <= REL_M;
              end
              default: state <= DIFF;
            endcase
          end else if (timed_out) begin
            // Abort: the unfinished phase reports zero and the result is flagged
            if (state == REQ_P || state == REL_P) y_plus <= '0;
            else                                  y_minus <= '0;
            timeout_err <= 1'b1;
            start_func  <= 1'b0;
            diff        <= '0;
            busy        <= 1'b0;
            done        <= 1'b1;
            wait_cnt    <= '0;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DIFF: begin
          diff  <= diff_calc;
          ovf   <= ovf_calc;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/func_grad_seq.md
# func_grad_seq

Initiator-side sequencer for the polynomial evaluator's start_func/func_done four-phase handshake. One request evaluates f(x+H) and f(x−H) back-to-back through a single attached evaluator, presents both results and their 128-bit difference (central-difference numerator), and reports saturation, overflow and handshake timeouts. Sits between the gradient/value-difference test controller and the `func` instance.

## Interface
- H, 32'h00000010, step size, signed Q24.8 (0.0625)
- TIMEOUT, 64, max cycles spent in any single wait state before aborting (≥ 2)
- clk  input  1  clock
- rst_n  input  1  reset; one clock, asynchronous, active-low
- start  input  1  request level from controller
- x_in  input  32  signed Q24.8 point, sampled in IDLE when start=1
- busy  output  1  high from accept until done asserts
- done  output  1  result valid; held until start deasserts
- y_plus, y_minus  output  128 each  signed Q120.8 f(x+H), f(x−H)
- diff  output  128  signed y_plus − y_minus, two's-complement wrap
- sat  output  1  x±H saturated to 32-bit range
- ovf  output  1  diff subtraction overflowed
- timeout_err  output  1  evaluator failed to respond within TIMEOUT
- start_func  output  1  request to evaluator
- x_func  output  32  signed Q24.8 operand to evaluator
- y_func  input  128  evaluator result
- func_done  input  1  evaluator completion level

## Operation
- States: IDLE, REQ_P, REL_P, REQ_M, REL_M, DIFF, DONE.
- IDLE: start=1 and func_done=0 → latch x_plus=sat(x_in+H), x_minus=sat(x_in−H) (33-bit add, clamp to 0x7FFFFFFF / 0x80000000); sat ← either clamped; clear ovf, timeout_err; → REQ_P. start=1 with func_done=1 → wait in IDLE.
- REQ_P: start_func=1, x_func=x_plus held stable; func_done=1 → capture y_plus ← y_func, → REL_P.
- REL_P: start_func=0; func_done=0 → REQ_M.
- REQ_M / REL_M: same as REQ_P / REL_P with x_minus / y_minus; REL_M exit → DIFF.
- DIFF: diff ← y_plus − y_minus (128-bit); ovf ← operand signs differ and result sign ≠ y_plus sign; → DONE.
- DONE: done=1, busy=0; start=0 → IDLE (done clears on that edge).
- Timeout: one cycle counter, cleared on every state change; reaching TIMEOUT in REQ_*/REL_* → timeout_err=1, start_func=0, diff=0, y_* of the unfinished phase = 0, → DONE. The next request from IDLE still waits for func_done=0.
- start toggling while busy is ignored; x_in is ignored after acceptance.
- x_func holds its last value outside REQ_* states.

## Timing
- All outputs are registered. Reset values: start_func=0, x_func=0, busy=0, done=0, y_plus=y_minus=diff=0, sat=ovf=timeout_err=0; state=IDLE, counter=0.
- Reset asserted mid-operation: start_func drops immediately (async); evaluator returns to idle through its own handshake.
- start_func rises on the edge after acceptance. busy rises on the same edge.
- Each REQ phase ends on the edge where func_done=1 is sampled. start_func falls on that edge.
- Against the team `func` (8 edges from start_func to func_done, 2 edges from release to func_done low), each phase takes 11 cycles. done asserts 24 cycles after the accept edge.
- DIFF lasts exactly 1 cycle. done asserts the edge after it.

## Test plan
- Linear: instantiate `func` with A0=0, A1=32'h200, others 0. x_in=32'h00000300, start held → y_plus=0x00000620, y_minus=0x000005E0, diff=0x40, done at cycle 24, sat=ovf=timeout_err=0.
- Symmetric: default cos coefficients, x_in=0 → y_plus==y_minus, diff=0.
- Saturation: x_in=32'h7FFFFFF8 → x_func=0x7FFFFFFF in the plus phase, x_func=0x7FFFFFE8 in the minus phase, sat=1.
- Timeout: evaluator model never raises func_done, TIMEOUT=32 → start_func drops after 32 cycles in REQ_P; timeout_err=1, diff=0, done=1.
- Handshake hold: start held 50 cycles after done → done stays 1. start=0 → done=0 next edge, busy=0. A second request is accepted only after func_done=0.
- Reset mid-REQ_M: rst_n low → start_func, done, busy = 0 immediately. After release, a fresh request completes correctly.
